// File: rtl/pwm_dac_pkg.sv
// Shared sound-generator constants and the PWM run/stop state type.
package pwm_dac_pkg;

    // Sample width shared with the mixer; the PWM width defaults to it.
    localparam int SAMPLE_W         = 8;
    // Default number of clocks per PWM step.
    localparam int PRESCALE_DEFAULT = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } run_state_e;

endpackage

// File: rtl/pwm_dac_step_prescaler.sv
// Step prescaler: emits a one-clock tick every PRESCALE clocks while not cleared.
// Shared with the tone generators.
module step_prescaler
    import pwm_dac_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_q;

    // With PRESCALE==1 presc_q is always 0, so tick reduces to ~clear.
    assign tick = !clear && (presc_q == LAST);

    // Step counter: held at 0 while cleared, wraps to 0 on tick.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (!rst_n) begin
            presc_q <= '0;
        end else if (clear || tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

endmodule

// File: rtl/pwm_dac.sv
// PWM audio DAC: latches the mixer sample at each period start and produces
// a registered single-bit PWM stream plus a period-start strobe.
module pwm_dac
    import pwm_dac_pkg::*;
#(
    parameter int WIDTH    = SAMPLE_W,
    parameter int PRESCALE = PRESCALE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] sample_in,
    output logic             pwm_out,
    output logic             period_start,
    output logic [WIDTH-1:0] duty
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    run_state_e       state_q, state_n;
    logic [WIDTH-1:0] cnt_q, cnt_n;
    logic [WIDTH-1:0] duty_q, duty_n;
    logic             pwm_q, pwm_n;
    logic             ps_q, ps_n;
    logic             clear;
    logic             tick;

    // The prescaler only runs while in RUN with enable held high.
    assign clear = (state_q != ST_RUN) || !enable;

    step_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .tick  (tick)
    );

    // Next-state logic: period starts, counter stepping and compare.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_n = state_q;
        cnt_n   = cnt_q;
        duty_n  = duty_q;
        pwm_n   = 1'b0;
        ps_n    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cnt_n = '0;
                if (enable) begin
                    state_n = ST_RUN;
                    duty_n  = sample_in;
                    pwm_n   = (sample_in != '0);
                    ps_n    = 1'b1;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    // Abandon the partial period; duty is kept for debug.
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end else if (tick && (cnt_q == CNT_MAX)) begin
                    // Wrap: new duty takes effect on the first clock of the period.
                    cnt_n  = '0;
                    duty_n = sample_in;
                    pwm_n  = (sample_in != '0);
                    ps_n   = 1'b1;
                end else begin
                    if (tick) begin
                        cnt_n = cnt_q + WIDTH'(1);
                    end
                    pwm_n = (cnt_n < duty_q);
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State register for control, counter, duty latch and outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            duty_q  <= '0;
            pwm_q   <= 1'b0;
            ps_q    <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            duty_q  <= duty_n;
            pwm_q   <= pwm_n;
            ps_q    <= ps_n;
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = ps_q;
    assign duty         = duty_q;

endmodule
